sine_quadrant_unfold: RTL and testbench

- Back end of the DDS sine path: rebuilds the full-wave output sample from the quarter-wave LUT magnitude.
- Input side: the upstream phase-folding stage sends the LUT only an 8-bit mirrored address, so the quadrant (phase[9:8]) is lost there. This block receives that quadrant directly and delays it to line up with the LUT read data.
- Output side: applies the sign for the negative half-cycle and produces a 9-bit offset-binary DAC code, plus zero-crossing and period-count status.

---
 rtl/sine_quadrant_unfold.sv | 92 +++++++++
 tb/tb_sine_quadrant_unfold.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_quadrant_unfold.sv
// DDS back end: delays the phase quadrant alongside the quarter-wave LUT read
// and unfolds the magnitude into a full-wave offset-binary sample.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_valid       phase word presented to the folding stage this cycle
//   quad_in        phase[9:8] of that phase word
//   lut_data       LUT magnitude, valid ADDR_LAT+LUT_LAT cycles after in_valid
//   sample_out     offset-binary sample (midscale 2^DW)
//   sample_valid   one-cycle strobe, sample_out updated this cycle
//   zero_cross     one-cycle pulse on a negative->positive crossing
//   period_cnt     rising crossings since reset (wraps)
`timescale 1ns/1ps
module sine_quadrant_unfold #(
  parameter int ADDR_LAT = 1,
  parameter int LUT_LAT  = 1,
  parameter int DW       = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       quad_in,
  input  logic [DW-1:0]    lut_data,
  output logic [DW:0]      sample_out,
  output logic             sample_valid,
  output logic             zero_cross,
  output logic [CNT_W-1:0] period_cnt
);

  localparam int D = ADDR_LAT + LUT_LAT;

  logic [D-1:0] tag_v;
  logic [1:0]   tag_q [D];

  logic          tv;
  logic [1:0]    tq;
  logic [DW:0]   unf;
  logic          rise;
  logic          have_prev;
  logic          prev_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= in_valid;
      for (int i = 1; i < D; i++) begin
        tag_v[i] <= tag_v[i-1];
      end
    end
  end

  // Quadrant tags carry no state of their own; the valid bits gate them.
  always_ff @(posedge clk) begin
    tag_q[0] <= quad_in;
    for (int i = 1; i < D; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign tv = tag_v[D-1];
  assign tq = tag_q[D-1];

  // Positive half: 2^DW + m. Negative half: 2^DW - 1 - m, i.e. ~m.
  assign unf = tq[1] ? {1'b0, ~lut_data} : {1'b1, lut_data};

  assign rise = tv & have_prev & prev_half & ~tq[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out   <= {1'b1, {DW{1'b0}}};
      sample_valid <= 1'b0;
      zero_cross   <= 1'b0;
      period_cnt   <= '0;
      have_prev    <= 1'b0;
      prev_half    <= 1'b0;
    end else begin
      sample_valid <= tv;
      zero_cross   <= rise;
      if (tv) begin
        sample_out <= unf;
        have_prev  <= 1'b1;
        prev_half  <= tq[1];
      end
      if (rise) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sine_quadrant_unfold.sv
// Directed bench for sine_quadrant_unfold: default, CNT_W=4 and
// ADDR_LAT=0/LUT_LAT=4 instances share one stimulus stream.
`timescale 1ns/1ps
module tb_sine_quadrant_unfold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv;
  logic [1:0] qi;
  logic [7:0] mi;
  logic [7:0] m_dl [4];

  logic [8:0]  so_a, so_b, so_c;
  logic        sv_a, sv_b, sv_c;
  logic        zc_a, zc_b, zc_c;
  logic [15:0] pc_a, pc_c;
  logic [3:0]  pc_b;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  always @(posedge clk) begin
    m_dl[0] <= mi;
    for (int i = 1; i < 4; i++) m_dl[i] <= m_dl[i-1];
  end

  sine_quadrant_unfold u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .quad_in(qi),
    .lut_data(m_dl[1]), .sample_out(so_a), .sample_valid(sv_a),
    .zero_cross(zc_a), .period_cnt(pc_a));

  sine_quadrant_unfold #(.CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .quad_in(qi),
    .lut_data(m_dl[1]), .sample_out(so_b), .sample_valid(sv_b),
    .zero_cross(zc_b), .period_cnt(pc_b));

  sine_quadrant_unfold #(.ADDR_LAT(0), .LUT_LAT(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .quad_in(qi),
    .lut_data(m_dl[3]), .sample_out(so_c), .sample_valid(sv_c),
    .zero_cross(zc_c), .period_cnt(pc_c));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [1:0] q,
                     input logic [7:0] m);
    iv = v; qi = q; mi = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] lut(input logic [7:0] a);
    real x;
    x = 255.0 * $sin(3.14159265358979 * (real'(a) + 0.5) / 512.0) + 0.5;
    return 8'($rtoi(x));
  endfunction

  task automatic test_reset();
    int bad;
    checks++;
    if (so_a !== 9'd256 || sv_a !== 1'b0 || zc_a !== 1'b0 || pc_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_init so=%0d sv=%b zc=%b pc=%0d want 256 0 0 0",
               so_a, sv_a, zc_a, pc_a);
    end
    rst_n = 1'b1;
    tick();
    drv(1, 2, 5); tick();
    drv(1, 0, 7); tick();
    drv(0, 0, 0); tick(); tick();
    checks++;
    if (pc_a !== 16'd1 || so_a !== 9'd263) begin
      errors++;
      $display("FAIL reset_warmup pc=%0d so=%0d want 1 263", pc_a, so_a);
    end
    drv(1, 1, 50); tick();
    drv(1, 3, 60); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (so_a !== 9'd256 || sv_a !== 1'b0 || pc_a !== 16'd0 || zc_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async so=%0d sv=%b pc=%0d zc=%b want 256 0 0 0",
               so_a, sv_a, pc_a, zc_a);
    end
    drv(0, 0, 0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sv_a !== 1'b0 || so_a !== 9'd256) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_flush stray=%0d want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drv(1, 0, 9); else drv(0, 0, 0);
      tick();
      if (i < 2 && sv_a !== 1'b0) bad++;
      if (i == 2) begin
        checks++;
        if (sv_a !== 1'b1 || so_a !== 9'd265 || zc_a !== 1'b0) begin
          errors++;
          $display("FAIL reset_first sv=%b so=%0d zc=%b want 1 265 0",
                   sv_a, so_a, zc_a);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_early early=%0d want 0", bad);
    end
  endtask

  task automatic test_mapping();
    logic [1:0] qv [4];
    logic [7:0] mv [4];
    logic [8:0] ev [4];
    qv = '{2'd0, 2'd1, 2'd2, 2'd3};
    mv = '{8'd0, 8'd255, 8'd0, 8'd255};
    ev = '{9'd256, 9'd511, 9'd255, 9'd0};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drv(1, qv[i], mv[i]); else drv(0, 0, 0);
      tick();
      checks++;
      if (i >= 2 && i <= 5) begin
        if (sv_a !== 1'b1 || so_a !== ev[i-2]) begin
          errors++;
          $display("FAIL map%0d sv=%b so=%0d want 1 %0d", i-2, sv_a, so_a, ev[i-2]);
        end
      end else if (sv_a !== 1'b0) begin
        errors++;
        $display("FAIL map_idle%0d sv=%b want 0", i, sv_a);
      end
    end
  endtask

  task automatic test_bubbles();
    logic       pat [7];
    logic [7:0] mv  [7];
    logic [8:0] eo  [8];
    logic       ev;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    mv  = '{8'd10, 8'd0, 8'd0, 8'd20, 8'd30, 8'd0, 8'd40};
    eo  = '{9'd266, 9'd266, 9'd266, 9'd276, 9'd286, 9'd286, 9'd296, 9'd296};
    for (int i = 0; i < 10; i++) begin
      if (i < 7) drv(pat[i], 0, mv[i]); else drv(0, 0, 0);
      tick();
      ev = (i >= 2 && i <= 8) ? pat[i-2] : 1'b0;
      checks++;
      if (sv_a !== ev || (i >= 2 && so_a !== eo[i-2])) begin
        errors++;
        $display("FAIL bubble%0d sv=%b so=%0d want %b %0d",
                 i, sv_a, so_a, ev, (i >= 2) ? eo[i-2] : so_a);
      end
    end
  endtask

  task automatic test_crossing();
    logic [1:0]  qs  [8];
    logic        ezc [8];
    logic [15:0] epc [8];
    qs  = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    ezc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    epc = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drv(1, qs[i], 8'd100); else drv(0, 0, 0);
      tick();
      if (i >= 2) begin
        checks++;
        if (sv_a !== 1'b1 || zc_a !== ezc[i-2] || pc_a !== epc[i-2]) begin
          errors++;
          $display("FAIL cross%0d sv=%b zc=%b pc=%0d want 1 %b %0d",
                   i-2, sv_a, zc_a, pc_a, ezc[i-2], epc[i-2]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int zcn;
    int s;
    zcn = 0;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      if (i < 34) drv(1, (i % 2 == 0) ? 2'd2 : 2'd0, 8'd77); else drv(0, 0, 0);
      tick();
      if (i >= 2) begin
        s = i - 2;
        if (zc_b === 1'b1) zcn++;
        if (s == 29) begin
          checks++;
          if (pc_b !== 4'd15) begin
            errors++;
            $display("FAIL wrap15 pc=%0d want 15", pc_b);
          end
        end
        if (s == 31) begin
          checks++;
          if (pc_b !== 4'd0) begin
            errors++;
            $display("FAIL wrap16 pc=%0d want 0", pc_b);
          end
        end
        if (s == 33) begin
          checks++;
          if (pc_b !== 4'd1 || pc_a !== 16'd17) begin
            errors++;
            $display("FAIL wrap17 pc_b=%0d pc_a=%0d want 1 17", pc_b, pc_a);
          end
        end
      end
    end
    checks++;
    if (zcn != 17) begin
      errors++;
      $display("FAIL wrap_pulses got=%0d want 17", zcn);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drv(1, 1, 8'd100); else drv(0, 0, 0);
      tick();
      checks++;
      if (sv_c !== (i == 4) || sv_a !== (i == 2)) begin
        errors++;
        $display("FAIL lat%0d sv_c=%b sv_a=%b want %b %b",
                 i, sv_c, sv_a, (i == 4), (i == 2));
      end
      if (i == 4) begin
        checks++;
        if (so_c !== 9'd356) begin
          errors++;
          $display("FAIL lat_val so_c=%0d want 356", so_c);
        end
      end
    end
  endtask

  task automatic test_full_period();
    logic [8:0] exq [1025];
    logic [9:0] ph;
    logic [7:0] a;
    logic [8:0] prev;
    int n, gaps, mism, mono, mn, mx, zcn, zci, q;
    n = 0; gaps = 0; mism = 0; mono = 0;
    mn = 1000; mx = -1; zcn = 0; zci = -1;
    prev = '0;
    do_reset();
    for (int p = 0; p < 1029; p++) begin
      if (p < 1025) begin
        ph = 10'(p % 1024);
        a  = ph[8] ? ~ph[7:0] : ph[7:0];
        drv(1, ph[9:8], lut(a));
        exq[p] = ph[9] ? {1'b0, ~lut(a)} : {1'b1, lut(a)};
      end else begin
        drv(0, 0, 0);
      end
      tick();
      if (sv_a === 1'b1) begin
        if (so_a !== exq[n]) mism++;
        if (zc_a === 1'b1) begin
          zcn++;
          zci = n;
        end
        if (n < 1024) begin
          if (int'(so_a) < mn) mn = int'(so_a);
          if (int'(so_a) > mx) mx = int'(so_a);
          q = (n >> 8) & 3;
          if (n % 256 != 0) begin
            if ((q == 0 || q == 3) && so_a < prev) mono++;
            if ((q == 1 || q == 2) && so_a > prev) mono++;
          end
        end
        prev = so_a;
        n++;
      end else if (n > 0 && n < 1025) begin
        gaps++;
      end
    end
    checks++;
    if (n != 1025 || gaps != 0) begin
      errors++;
      $display("FAIL sweep_count n=%0d gaps=%0d want 1025 0", n, gaps);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL sweep_values bad=%0d want 0", mism);
    end
    checks++;
    if (mono != 0) begin
      errors++;
      $display("FAIL sweep_mono bad=%0d want 0", mono);
    end
    checks++;
    if (mn != 0 || mx != 511) begin
      errors++;
      $display("FAIL sweep_range min=%0d max=%0d want 0 511", mn, mx);
    end
    checks++;
    if (zcn != 1 || zci != 1024 || pc_a !== 16'd1) begin
      errors++;
      $display("FAIL sweep_cross n=%0d at=%0d pc=%0d want 1 1024 1",
               zcn, zci, pc_a);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0);
    tick();
    tick();
    test_reset();
    test_mapping();
    test_bubbles();
    test_crossing();
    test_wrap();
    test_latency();
    test_full_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
